// File: rtl/neuron_pkg.sv
// Shared Q8.8 constants, FSM state type and product helper for the neuron MAC.
package neuron_pkg;

    // Q8.8 fixed-point format: 8 integer bits, 8 fractional bits.
    localparam int          FRAC_BITS = 8;
    localparam logic [15:0] Q88_MAX   = 16'h7FFF;
    localparam logic [15:0] Q88_MIN   = 16'h8000;
    localparam logic [15:0] Q88_ONE   = 16'h0100;

    // Dot-product controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Q8.8 x Q8.8 product, rescaled to Q8.8 in 32 bits.
    // Both operands are widened to 32 bits before multiplying, so the
    // 0x8000 * 0x8000 corner (+2^30) fits without wrapping. The arithmetic
    // shift rounds toward minus infinity.
    function automatic logic signed [31:0] q88_mul(input logic signed [15:0] a,
                                                   input logic signed [15:0] b);
        logic signed [31:0] full;
        full = 32'(a) * 32'(b);
        return full >>> FRAC_BITS;
    endfunction

endpackage

// File: rtl/q88_saturate.sv
// Clamps a wide signed accumulator to a signed Q8.8 word.
module q88_saturate
    import neuron_pkg::*;
#(
    parameter int ACC_W = 32
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic [15:0]             sum_o
);

    logic fits;

    // The value fits in 16 bits when every bit above bit 15 copies the sign bit.
    assign fits = (acc_i[ACC_W-1:15] == {(ACC_W-15){acc_i[ACC_W-1]}});

    // Pass through when in range, otherwise clamp toward the sign of acc_i.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path; otherwise a latch is inferred.
        sum_o = acc_i[15:0];
        if (!fits) begin
            sum_o = acc_i[ACC_W-1] ? Q88_MIN : Q88_MAX;
        end
    end

endmodule

// File: rtl/neuron_mac.sv
// Neuron multiply-accumulate stage: bias + sum of Q8.8 x*w products,
// saturated to Q8.8 at the output, with valid/ready handshakes on both sides.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int MAX_TERMS = 16,
    parameter int ACC_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    input  logic [15:0] in_w,
    input  logic        in_last,
    input  logic [15:0] bias,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_trunc
);

    localparam int               CNT_W   = $clog2(MAX_TERMS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    // The accumulator must hold a full Q8.8 word plus growth headroom.
    if (ACC_W < 24) begin : g_acc_w_check
        $error("neuron_mac: ACC_W must be at least 24");
    end

    // Registered state and outputs.
    state_e                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic [15:0]             out_sum_q;
    logic                    out_trunc_q;

    // Datapath values for the beat being offered this cycle.
    logic signed [31:0]      prod_shr;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_d;
    logic [CNT_W-1:0]        cnt_d;
    logic                    beat_fire;
    logic                    hit_max;
    logic [15:0]             sum_sat;

    // Beat acceptance, product scaling and next accumulator / term count.
    always_comb begin
        beat_fire = in_valid && in_ready_q;
        prod_shr  = q88_mul(in_x, in_w);
        prod_ext  = ACC_W'(prod_shr);
        bias_ext  = ACC_W'($signed(bias));
        // The first beat of a dot product starts from the bias, later beats
        // build on the running sum.
        if (state_q == IDLE) begin
            acc_base = bias_ext;
            cnt_d    = CNT_W'(1);
        end else begin
            acc_base = acc_q;
            cnt_d    = cnt_q + CNT_W'(1);
        end
        acc_d   = acc_base + prod_ext;
        hit_max = (cnt_d == MAX_CNT);
    end

    // Clamp is applied to the value being captured as the result only;
    // the accumulator itself never saturates.
    q88_saturate #(
        .ACC_W (ACC_W)
    ) u_sat (
        .acc_i (acc_d),
        .sum_o (sum_sat)
    );

    // Controller: accumulates beats, captures the result on the terminating
    // beat and holds it until the consumer takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
            case (state_q)
                IDLE, ACCUM: begin
                    if (beat_fire) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (in_last || hit_max) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_sum_q   <= sum_sat;
                            // Truncated only when the term limit ended it
                            // without the producer marking the last beat.
                            out_trunc_q <= !in_last;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    // in_ready reopens one cycle after the output handshake;
                    // there is no same-cycle path from out_ready to in_ready.
                    if (out_ready) begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_trunc_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    out_trunc_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_trunc = out_trunc_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Self-checking bench for neuron_mac: table-driven dot products with a
// result scoreboard, plus hand-written backpressure, truncation and reset
// sequences.
module tb_neuron_mac;
    import neuron_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_w;
    logic        in_last;
    logic [15:0] bias;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_trunc;

    neuron_mac #(
        .MAX_TERMS (16),
        .ACC_W     (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_w      (in_w),
        .in_last   (in_last),
        .bias      (bias),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_trunc (out_trunc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0]      bias;
        int               n;
        logic [3:0][15:0] x;
        logic [3:0][15:0] w;
        logic [15:0]      exp_sum;
        logic             exp_trunc;
    } vec_t;

    typedef struct packed {
        logic [15:0] sum;
        logic        trunc;
    } exp_t;

    localparam int NV = 10;

    vec_t vecs[NV];
    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] b, input int n,
                                input logic [15:0] x0, input logic [15:0] w0,
                                input logic [15:0] x1, input logic [15:0] w1,
                                input logic [15:0] x2, input logic [15:0] w2,
                                input logic [15:0] x3, input logic [15:0] w3,
                                input logic [15:0] es, input logic et);
        vec_t v;
        v.bias = b;
        v.n    = n;
        v.x[0] = x0; v.w[0] = w0;
        v.x[1] = x1; v.w[1] = w1;
        v.x[2] = x2; v.w[2] = w2;
        v.x[3] = x3; v.w[3] = w3;
        v.exp_sum   = es;
        v.exp_trunc = et;
        return v;
    endfunction

    // Reference: exact integer sum with floor-rescaled products, clamped once.
    function automatic logic [15:0] model(input logic [15:0] b, input int n,
                                          input logic [3:0][15:0] x,
                                          input logic [3:0][15:0] w);
        longint acc;
        int     p;
        acc = longint'($signed(b));
        for (int k = 0; k < n; k++) begin
            p   = int'($signed(x[k])) * int'($signed(w[k]));
            acc = acc + longint'(p >>> 8);
        end
        if (acc > 32767)       return 16'h7FFF;
        else if (acc < -32768) return 16'h8000;
        else                   return acc[15:0];
    endfunction

    // Offers one beat and waits (bounded) until it is accepted.
    // Returns #1 after the accepting clock edge.
    task automatic drive_beat(input logic [15:0] x, input logic [15:0] w,
                              input logic [15:0] b, input logic last);
        logic accepted;
        int   guard;
        guard    = 0;
        accepted = 1'b0;
        in_valid = 1'b1;
        in_x     = x;
        in_w     = w;
        bias     = b;
        in_last  = last;
        do begin
            accepted = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!accepted && guard < 64);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!accepted) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_accept: in_ready stayed 0 for %0d cycles", guard);
        end
    endtask

    // Waits (bounded) for every expected result to be taken by the monitor.
    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 60) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("scoreboard_drained", 16'(sb.size()), 16'd0);
        sb.delete();
    endtask

    // Monitor: compares each output handshake against the scoreboard.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got out_sum=%h, expected no result", out_sum);
            end else begin
                mon_e = sb.pop_front();
                check("out_sum", out_sum, mon_e.sum);
                check("out_trunc", 16'(out_trunc), 16'(mon_e.trunc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        lst;
        logic [15:0] bb;
        vec_t        rv;

        // Beats not used by a vector are zero.
        vecs[0] = mk(16'h0080, 3, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0100, 16'h0200, 16'h0, 16'h0, 16'h0680, 1'b0);
        vecs[1] = mk(16'h0000, 1, 16'hFF00, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFF00, 1'b0);
        vecs[2] = mk(16'h7F00, 1, 16'h7FFF, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 1'b0);
        vecs[3] = mk(16'h0000, 1, 16'h8000, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 1'b0);
        // +2^22 then -4194176: wide intermediate must survive unclamped.
        vecs[4] = mk(16'h0000, 2, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0080, 1'b0);
        // -1 * 1 raw = -1, shifted right by 8 floors to -1.
        vecs[5] = mk(16'h0000, 1, 16'hFFFF, 16'h0001, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 1'b0);
        // -128 + 96 - 1536 = -1568.
        vecs[6] = mk(16'hFF80, 2, 16'h0180, 16'h0040, 16'hFE00, 16'h0300, 16'h0, 16'h0, 16'h0, 16'h0, 16'hF9E0, 1'b0);
        // 32767 + 1 = 32768 clamps high.
        vecs[7] = mk(16'h7FFF, 1, 16'h0001, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 1'b0);
        // -32768 - 1 clamps low.
        vecs[8] = mk(16'h8000, 1, 16'hFFFF, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 1'b0);
        // 32512 + 255 = 32767 exactly, no clamp.
        vecs[9] = mk(16'h7F00, 1, 16'h0100, 16'h00FF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 1'b0);

        reset     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_w      = '0;
        in_last   = 1'b0;
        bias      = '0;
        out_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_out_valid", 16'(out_valid), 16'd0);
        check("rst_out_sum", out_sum, 16'h0000);
        check("rst_out_trunc", 16'(out_trunc), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_in_ready", 16'(in_ready), 16'd1);
        @(posedge clk);
        #1;

        // Table vectors; bias on non-first beats is noise that must be ignored.
        for (int i = 0; i < NV; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                lst = (k == vecs[i].n - 1);
                bb  = (k == 0) ? vecs[i].bias : 16'($urandom);
                if (lst) sb.push_back('{sum: vecs[i].exp_sum, trunc: vecs[i].exp_trunc});
                drive_beat(vecs[i].x[k], vecs[i].w[k], bb, lst);
            end
        end
        drain();

        // Random dot products against the reference model.
        for (int r = 0; r < 6; r++) begin
            rv.bias = 16'($urandom);
            rv.n    = int'($urandom_range(1, 4));
            for (int k = 0; k < 4; k++) begin
                rv.x[k] = (r < 3) ? 16'($urandom_range(0, 16'h03FF)) - 16'h0200 : 16'($urandom);
                rv.w[k] = (r < 3) ? 16'($urandom_range(0, 16'h03FF)) - 16'h0200 : 16'($urandom);
            end
            for (int k = 0; k < rv.n; k++) begin
                lst = (k == rv.n - 1);
                if (lst) sb.push_back('{sum: model(rv.bias, rv.n, rv.x, rv.w), trunc: 1'b0});
                drive_beat(rv.x[k], rv.w[k], rv.bias, lst);
            end
        end
        drain();

        // Basic: result valid for exactly one cycle when taken at once.
        sb.push_back('{sum: 16'h0680, trunc: 1'b0});
        drive_beat(16'h0100, 16'h0200, 16'h0080, 1'b0);
        drive_beat(16'h0100, 16'h0200, 16'h0080, 1'b0);
        drive_beat(16'h0100, 16'h0200, 16'h0080, 1'b1);
        check("basic_valid_hi", 16'(out_valid), 16'd1);
        check("basic_in_ready_lo", 16'(in_ready), 16'd0);
        @(posedge clk);
        #1;
        check("basic_valid_lo", 16'(out_valid), 16'd0);
        check("basic_in_ready_hi", 16'(in_ready), 16'd1);
        drain();

        // Backpressure: 0x0100 + (0x0200*0x0180 >> 8) = 0x0400.
        out_ready = 1'b0;
        sb.push_back('{sum: 16'h0400, trunc: 1'b0});
        drive_beat(16'h0200, 16'h0180, 16'h0100, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid_hold", 16'(out_valid), 16'd1);
            check("bp_sum_hold", out_sum, 16'h0400);
            check("bp_trunc_hold", 16'(out_trunc), 16'd0);
            check("bp_in_ready_lo", 16'(in_ready), 16'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid_lo", 16'(out_valid), 16'd0);
        check("bp_release_in_ready", 16'(in_ready), 16'd1);
        drain();

        // Truncation: 16 beats of 0x10, never last, with idle gaps.
        for (int k = 0; k < 16; k++) begin
            if (k == 15) sb.push_back('{sum: 16'h0100, trunc: 1'b1});
            drive_beat(16'h0100, 16'h0010, 16'h0000, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drain();

        // 16 beats with last on the 16th: not a truncation.
        for (int k = 0; k < 16; k++) begin
            lst = (k == 15);
            if (lst) sb.push_back('{sum: Q88_ONE, trunc: 1'b0});
            drive_beat(16'h0100, 16'h0010, 16'h0000, lst);
        end
        drain();

        // Reset mid-accumulation discards the partial sum.
        drive_beat(16'h0100, 16'h0100, 16'h0100, 1'b0);
        drive_beat(16'h0100, 16'h0100, 16'h0100, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_accum_valid", 16'(out_valid), 16'd0);
        check("rst_accum_sum", out_sum, 16'h0000);
        check("rst_accum_trunc", 16'(out_trunc), 16'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_accum_in_ready", 16'(in_ready), 16'd1);
        @(posedge clk);
        #1;
        sb.push_back('{sum: 16'h0310, trunc: 1'b0});
        drive_beat(16'h0100, 16'h0300, 16'h0010, 1'b1);
        drain();

        // Reset while a result is pending drops it with no output beat.
        out_ready = 1'b0;
        drive_beat(16'h0100, 16'h0200, 16'h0000, 1'b1);
        check("rst_done_valid_before", 16'(out_valid), 16'd1);
        check("rst_done_sum_before", out_sum, 16'h0200);
        #2;
        reset = 1'b0;
        #1;
        check("rst_done_valid", 16'(out_valid), 16'd0);
        check("rst_done_sum", out_sum, 16'h0000);
        @(negedge clk);
        reset     = 1'b1;
        out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rst_done_no_output", 16'(out_valid), 16'd0);
        check("rst_done_in_ready", 16'(in_ready), 16'd1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
